soc_system_arm2nios_mailbox: RTL and testbench
==============================================

# soc_system_arm2nios_mailbox

ARM-to-Nios mailbox that sits directly upstream of the `soc_system_Data_ARM2Nios_in` PIO. The ARM HPS writes 32-bit words over an Avalon-MM slave into a small FIFO. The block presents one word at a time on `out_data`, which drives the PIO's `in_port`. A toggle request/acknowledge pair tells the Nios when a new word is valid and when it has been consumed.

## Interface
- `DEPTH`, 4: FIFO depth in words; power of two, 2..64.
- `LEVEL_W`, 3: width of the level field; equals log2(`DEPTH`)+1.
- `clk`  in  1  system clock; single clock domain with the Nios PIOs.
- `reset_n`  in  1  asynchronous, active-low reset.
- `address`  in  2  Avalon slave word address.
- `chipselect`  in  1  Avalon slave select.
- `write_n`  in  1  Avalon write strobe, active low; a write happens when `chipselect`=1 and `write_n`=0.
- `writedata`  in  32  Avalon write data.
- `readdata`  out  32  registered Avalon read data.
- `out_data`  out  32  word presented to the Nios (connects to the PIO `in_port`).
- `out_req`  out  1  request toggle; inverts once per newly presented word.
- `in_ack`  in  1  acknowledge toggle from a Nios output PIO; same clock domain, no synchroniser.
- `irq`  out  1  level interrupt to the ARM; asserts when the mailbox is drained.

## Operation
- **Register map, writes**
  - addr 0: push `writedata` into the FIFO.
  - addr 1: any value clears `ovf_cnt`.
  - addr 2: bit0 loads `irq_mask`.
  - addr 3: bit0=1 flushes the FIFO.
- **Register map, reads**
  - addr 0: status. [LEVEL_W-1:0]=level (0..DEPTH), [8]=empty, [9]=full, [10]=pending, all other bits 0.
  - addr 1: {16'b0, ovf_cnt}.
  - addr 2: {31'b0, irq_mask}.
  - addr 3: 0.
- **Read path**
  - `readdata` is loaded every cycle from the mux selected by `address`, independent of `chipselect` (PIO-style).
  - Read latency is 1 cycle.
- **Pending flag**
  - pending = `out_req` XOR `in_ack`.
- **State machine, IDLE**
  - If the FIFO is non-empty and no flush is happening this cycle: load the FIFO head into `out_data`, pop the FIFO, toggle `out_req`, and go to PRESENT.
- **State machine, PRESENT**
  - Hold `out_data` stable.
  - When `in_ack` equals `out_req`, go to IDLE.
  - The next load cannot happen earlier than the cycle after IDLE is entered.
- **Push rules**
  - A push when the FIFO is not full is accepted.
  - A push when the FIFO is full and no pop happens in the same cycle is dropped; `ovf_cnt` increments and saturates at 0xFFFF.
  - A push and a pop in the same cycle are both performed; the level is unchanged. This holds even when the FIFO is full.
- **Overflow counter**
  - A clear of `ovf_cnt` and an overflow in the same cycle: the clear wins, `ovf_cnt`=0.
- **Flush**
  - Sets level to 0 and resets the read and write pointers.
  - Suppresses any IDLE load in the same cycle.
  - Does not disturb a word already in PRESENT; `out_data`, `out_req` and the state are unchanged.
- **FIFO pointers**
  - Read and write pointers are log2(DEPTH) bits wide and wrap modulo `DEPTH`.
  - Level is tracked separately (0..DEPTH), so full and empty are unambiguous.
- **Interrupt**
  - `irq` = `irq_mask` AND empty AND NOT pending.
  - `irq` is registered and updates one cycle after its inputs change.

## Timing
- **Reset values:** `readdata`=0, `out_data`=0, `out_req`=0, `irq`=0, `irq_mask`=0, `ovf_cnt`=0, level=0, pointers=0, state=IDLE.
- **Push to presentation:** a push at edge N into an empty FIFO while IDLE. The word appears on `out_data` and `out_req` toggles at edge N+1, and level returns to 0 at N+1.
- **Ack to next word:** `in_ack` changes before edge M. State returns to IDLE at M, and the next word loads at M+1.
- **Throughput:** one word per 2 cycles, best case.
- **Status visibility:** status reads reflect state as of the edge at which `readdata` is loaded.
- **Mid-operation reset:** reset asserted at any point forces all reset values asynchronously. FIFO contents are lost and no partial word is presented.

## Test plan
- **Reset:** assert `reset_n`=0 while a word is pending. Required: `out_req`=0, `out_data`=0, status read returns 0x100 (empty).
- **Single word:** push 0xDEADBEEF. Required: `out_data`=0xDEADBEEF and `out_req` goes 0→1 one cycle later. Raise `in_ack`=1; the next status read shows pending=0 and empty=1.
- **Overflow:** with `DEPTH`=4 and the Nios never acking, push 6 words. Required:
  - 1 word presented and 4 queued (level=4, full=1).
  - `ovf_cnt`=1.
  - Writing addr 1 clears it to 0.
- **Wrap-around:** stream 20 words 0..19 with prompt acks. Required: `out_data` shows 0..19 in order with no loss; pointers wrap 5 times.
- **Flush:** queue 3 words with one pending, then write addr 3 = 1. Required:
  - level=0.
  - The pending word is held until acked.
  - No further `out_req` toggle after the ack.
- **Interrupt:** set `irq_mask`=1, push one word, then ack it. Required: `irq` is 0 while the word is queued or pending, and rises 1 cycle after the ack.

Source files
------------

// File: rtl/soc_system_arm2nios_mailbox.sv
// Purpose: ARM-to-Nios mailbox; Avalon-MM writes fill a small FIFO, words are handed to the Nios PIO one at a time.
// Latency: push into an empty FIFO is presented one cycle later; Avalon reads return after one cycle.
// Backpressure: toggle req/ack handshake towards the Nios; pushes into a full FIFO with no pop are dropped and counted.
module soc_system_arm2nios_mailbox #(
  parameter int DEPTH   = 4,
  parameter int LEVEL_W = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [31:0] out_data,
  output logic        out_req,
  input  logic        in_ack,
  output logic        irq
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t             state_q, state_d;
  logic [31:0]        mem_q [DEPTH];
  logic [31:0]        mem_d [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [31:0]        out_data_q, out_data_d;
  logic               out_req_q, out_req_d;
  logic [15:0]        ovf_cnt_q, ovf_cnt_d;
  logic               irq_mask_q, irq_mask_d;
  logic               irq_q, irq_d;
  logic [31:0]        readdata_q, readdata_d;

  // ---------------------------------------------------------------------------
  // Avalon write decode
  // ---------------------------------------------------------------------------
  logic wr_en;
  logic push_wr;
  logic ovf_clr;
  logic mask_wr;
  logic flush;

  assign wr_en   = chipselect & ~write_n;
  assign push_wr = wr_en & (address == 2'd0);
  assign ovf_clr = wr_en & (address == 2'd1);
  assign mask_wr = wr_en & (address == 2'd2);
  assign flush   = wr_en & (address == 2'd3) & writedata[0];

  // ---------------------------------------------------------------------------
  // FIFO status and handshake flags
  // ---------------------------------------------------------------------------
  logic fifo_empty;
  logic fifo_full;
  logic pending;
  logic pop;
  logic push_ok;
  logic ovf_evt;

  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == LEVEL_W'(DEPTH));
  // A word is outstanding while the Nios has not mirrored the request toggle.
  assign pending    = out_req_q ^ in_ack;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok    = push_wr & (~fifo_full | pop);
  assign ovf_evt    = push_wr & fifo_full & ~pop;

  // Handshake FSM: load the FIFO head in IDLE, hold it in PRESENT until acked.
  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_req_d  = out_req_q;
    pop        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A flush in the same cycle empties the FIFO, so nothing may be taken.
        if (!fifo_empty && !flush) begin
          out_data_d = mem_q[rd_ptr_q];
          out_req_d  = ~out_req_q;
          pop        = 1'b1;
          state_d    = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (in_ack == out_req_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FIFO storage, pointers and level; flush only clears bookkeeping, not the presented word.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = writedata;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push_ok, pop})
        2'b10:   level_d = level_q + LEVEL_W'(1);
        2'b01:   level_d = level_q - LEVEL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Control registers: overflow counter (clear beats increment), irq mask, registered irq.
  always_comb begin
    ovf_cnt_d  = ovf_cnt_q;
    irq_mask_d = irq_mask_q;
    if (ovf_clr) begin
      ovf_cnt_d = '0;
    end else if (ovf_evt && (ovf_cnt_q != 16'hFFFF)) begin
      ovf_cnt_d = ovf_cnt_q + 16'd1;
    end
    if (mask_wr) begin
      irq_mask_d = writedata[0];
    end
    irq_d = irq_mask_q & fifo_empty & ~pending;
  end

  // Read mux, sampled every cycle regardless of chipselect.
  always_comb begin
    readdata_d = '0;
    case (address)
      2'd0: begin
        readdata_d[LEVEL_W-1:0] = level_q;
        readdata_d[8]           = fifo_empty;
        readdata_d[9]           = fifo_full;
        readdata_d[10]          = pending;
      end
      2'd1:    readdata_d = {16'b0, ovf_cnt_q};
      2'd2:    readdata_d = {31'b0, irq_mask_q};
      default: readdata_d = '0;
    endcase
  end

  // State register bank with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      out_data_q <= '0;
      out_req_q  <= 1'b0;
      ovf_cnt_q  <= '0;
      irq_mask_q <= 1'b0;
      irq_q      <= 1'b0;
      readdata_q <= '0;
    end else begin
      state_q    <= state_d;
      mem_q      <= mem_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
      out_data_q <= out_data_d;
      out_req_q  <= out_req_d;
      ovf_cnt_q  <= ovf_cnt_d;
      irq_mask_q <= irq_mask_d;
      irq_q      <= irq_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign out_data = out_data_q;
  assign out_req  = out_req_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_soc_system_arm2nios_mailbox.sv
// Bench for the ARM-to-Nios mailbox: directed Avalon traffic, Nios ack responder, scoreboard monitor.
// Expected presented words and timed probes are queued by the stimulus; the monitor compares them.
// The responder mirrors out_req onto in_ack on the falling edge whenever acking is enabled.
module tb_soc_system_arm2nios_mailbox;

  localparam int K_RD    = 0;
  localparam int K_IRQ   = 1;
  localparam int K_REQ   = 2;
  localparam int K_DATA  = 3;
  localparam int K_TMO   = 4;
  localparam int K_DRAIN = 5;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    int          due;
    int          tag;
  } chk_t;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] out_data;
  logic        out_req;
  logic        in_ack;
  logic        irq;

  logic        ack_en;
  int          cyc;
  int          tag;
  int          n_chk;
  int          n_fail;
  chk_t        chk_q[$];
  logic [31:0] data_q[$];

  soc_system_arm2nios_mailbox #(.DEPTH(4), .LEVEL_W(3)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_data   (out_data),
    .out_req    (out_req),
    .in_ack     (in_ack),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic string kname(input int k);
    case (k)
      K_RD:    return "readdata";
      K_IRQ:   return "irq";
      K_REQ:   return "out_req";
      K_DATA:  return "out_data";
      K_TMO:   return "timeout";
      K_DRAIN: return "words_left";
      default: return "unknown";
    endcase
  endfunction

  function automatic logic [31:0] sample(input int k);
    case (k)
      K_RD:    return readdata;
      K_IRQ:   return {31'b0, irq};
      K_REQ:   return {31'b0, out_req};
      K_DATA:  return out_data;
      K_TMO:   return 32'd1;
      K_DRAIN: return 32'(data_q.size());
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  // Nios responder: acknowledges a presented word on the falling edge when enabled.
  initial begin
    in_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) in_ack = 1'b0;
      else if (ack_en && (in_ack != out_req)) in_ack = out_req;
    end
  end

  // Monitor: checks every out_req toggle against the expected word queue and runs due probes.
  initial begin
    logic        prev_req;
    logic [31:0] exp_w;
    logic [31:0] act;
    chk_t        keep[$];
    prev_req = 1'b0;
    cyc      = 0;
    n_chk    = 0;
    n_fail   = 0;
    forever begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (!reset_n) begin
        prev_req = 1'b0;
      end else if (out_req !== prev_req) begin
        prev_req = out_req;
        n_chk++;
        if (data_q.size() == 0) begin
          n_fail++;
          $display("FAIL present: unexpected word %h at cycle %0d, required no new word", out_data, cyc);
        end else begin
          exp_w = data_q.pop_front();
          if (out_data !== exp_w) begin
            n_fail++;
            $display("FAIL present: out_data %h, required %h (cycle %0d)", out_data, exp_w, cyc);
          end
        end
      end
      keep = {};
      foreach (chk_q[i]) begin
        if (chk_q[i].due > cyc) begin
          keep.push_back(chk_q[i]);
        end else begin
          n_chk++;
          act = sample(chk_q[i].kind);
          if ((chk_q[i].due != cyc) || (act !== chk_q[i].exp)) begin
            n_fail++;
            $display("FAIL %s #%0d: got %h, required %h (due %0d, now %0d)",
                     kname(chk_q[i].kind), chk_q[i].tag, act, chk_q[i].exp, chk_q[i].due, cyc);
          end
        end
      end
      chk_q = keep;
    end
  end

  // Stimulus helpers: inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_chk(input int k, input logic [31:0] e, input int due);
    chk_t c;
    tag++;
    c.kind = k;
    c.exp  = e;
    c.due  = due;
    c.tag  = tag;
    chk_q.push_back(c);
  endtask

  task automatic probe(input int k, input logic [31:0] e);
    add_chk(k, e, cyc);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e);
    address = a;
    add_chk(K_RD, e, cyc + 1);
    tick();
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((data_q.size() != 0) && (n < budget)) begin
      tick();
      n++;
    end
    if (data_q.size() != 0) add_chk(K_TMO, 32'd0, cyc);
  endtask

  initial begin
    tag        = 0;
    ack_en     = 1'b0;
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = '0;
    tick();
    tick();

    // Reset values
    probe(K_REQ, 32'd0);
    probe(K_DATA, 32'd0);
    probe(K_IRQ, 32'd0);
    probe(K_RD, 32'd0);
    reset_n = 1'b1;
    rd(2'd0, 32'h100);

    // Single word, then ack
    data_q.push_back(32'hDEADBEEF);
    wr(2'd0, 32'hDEADBEEF);
    probe(K_REQ, 32'd0);
    tick();
    probe(K_REQ, 32'd1);
    probe(K_DATA, 32'hDEADBEEF);
    rd(2'd0, 32'h500);
    ack_en = 1'b1;
    rd(2'd0, 32'h100);

    // Overflow: six pushes, Nios silent
    ack_en = 1'b0;
    data_q.push_back(32'hA0);
    for (int i = 0; i < 6; i++) wr(2'd0, 32'hA0 + 32'(i));
    rd(2'd0, 32'h604);
    rd(2'd1, 32'd1);
    wr(2'd1, 32'd0);
    rd(2'd1, 32'd0);
    probe(K_DATA, 32'hA0);

    // Push and pop together while full: level stays 4, nothing dropped
    for (int i = 1; i < 5; i++) data_q.push_back(32'hA0 + 32'(i));
    data_q.push_back(32'hB0);
    ack_en = 1'b1;
    tick();
    wr(2'd0, 32'hB0);
    rd(2'd0, 32'h204);
    rd(2'd1, 32'd0);
    wait_drain(40);
    repeat (3) tick();

    // Reset while a word is pending and another is queued
    ack_en = 1'b0;
    data_q.push_back(32'hC0);
    wr(2'd0, 32'hC0);
    wr(2'd0, 32'hC1);
    tick();
    reset_n = 1'b0;
    probe(K_REQ, 32'd0);
    probe(K_DATA, 32'd0);
    probe(K_IRQ, 32'd0);
    probe(K_RD, 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    rd(2'd0, 32'h100);
    probe(K_REQ, 32'd0);

    // Wrap-around: 20 words with prompt acks
    ack_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      data_q.push_back(32'(i));
      wr(2'd0, 32'(i));
      tick();
    end
    wait_drain(60);
    repeat (2) tick();
    rd(2'd1, 32'd0);
    rd(2'd0, 32'h100);
    probe(K_REQ, 32'd0);

    // Flush with one word presented and three queued
    ack_en = 1'b0;
    data_q.push_back(32'hF0);
    for (int i = 0; i < 4; i++) wr(2'd0, 32'hF0 + 32'(i));
    rd(2'd0, 32'h403);
    wr(2'd3, 32'd1);
    rd(2'd0, 32'h500);
    probe(K_DATA, 32'hF0);
    probe(K_REQ, 32'd1);
    ack_en = 1'b1;
    repeat (6) tick();
    rd(2'd0, 32'h100);
    probe(K_REQ, 32'd1);

    // Flush on the cycle an idle load would have happened
    ack_en = 1'b0;
    wr(2'd0, 32'hE0);
    wr(2'd3, 32'd1);
    tick();
    tick();
    rd(2'd0, 32'h100);
    probe(K_REQ, 32'd1);

    // Interrupt
    wr(2'd2, 32'd1);
    rd(2'd2, 32'd1);
    probe(K_IRQ, 32'd1);
    data_q.push_back(32'h1234);
    wr(2'd0, 32'h1234);
    probe(K_IRQ, 32'd1);
    tick();
    probe(K_IRQ, 32'd0);
    probe(K_REQ, 32'd0);
    tick();
    probe(K_IRQ, 32'd0);
    ack_en = 1'b1;
    tick();
    probe(K_IRQ, 32'd1);
    wr(2'd2, 32'd0);
    tick();
    probe(K_IRQ, 32'd0);
    rd(2'd2, 32'd0);

    // Every expected word must have been presented
    wait_drain(20);
    add_chk(K_DRAIN, 32'd0, cyc);
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
